// File: rtl/divider_unit_pkg.sv
// ============================================================================
// Module   : divider_unit_pkg
// Purpose  : Shared execution-unit definitions for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package divider_unit_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_iter = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = c_st_idle,
        ST_ITER = c_st_iter,
        ST_FIX  = c_st_fix,
        ST_DONE = c_st_done
    } state_t;

    // Widest datapath served; narrower units slice the constant below.
    localparam int c_width_max = 64;
    localparam logic [c_width_max-1:0] c_dbz_quotient = '1;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/divider_unit_adder.sv
// ============================================================================
// Module   : divider_unit_adder
// Purpose  : Common ripple adder with carry in/out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_unit_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{WIDTH{1'b0}}, i_cin};

endmodule

`default_nettype wire

// File: rtl/divider_unit.sv
// ============================================================================
// Module   : divider_unit
// Purpose  : Radix-2 restoring signed/unsigned divider, RISC-V M result rules.
//            Build option DIVIDER_ZERO_SHORTCUT_EN: zero divisor skips ITER.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_unit
    import divider_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_dvd;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_dbz_pend;
    logic               r_done;
    logic [WIDTH-1:0]   r_quotient;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_div_by_zero;

    logic               w_dvd_neg;
    logic               w_dvs_neg;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic               w_dvs_zero;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_take;
    logic               w_unused_diff_msb;

    assign w_dvd_neg  = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg  = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag  = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag  = w_dvs_neg ? -divisor  : divisor;
    assign w_dvs_zero = (divisor == '0);

    assign w_shift = {r_rem, r_quo[WIDTH-1]};

    // Carry out of shift + ~divisor + 1 is set exactly when shift >= divisor.
    divider_unit_adder #(
        .WIDTH (WIDTH + 1)
    ) u_trial_sub (
        .i_a    (w_shift),
        .i_b    (~{1'b0, r_dvs}),
        .i_cin  (1'b1),
        .o_sum  (w_diff),
        .o_cout (w_take)
    );

    assign w_unused_diff_msb = w_diff[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
`ifdef DIVIDER_ZERO_SHORTCUT_EN
                    w_next_state = w_dvs_zero ? ST_FIX : ST_ITER;
`else
                    w_next_state = ST_ITER;
`endif
                end
            end
            ST_ITER: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_FIX;
                end
            end
            ST_FIX:  w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvs         <= '0;
            r_dvd         <= '0;
            r_qneg        <= 1'b0;
            r_rneg        <= 1'b0;
            r_dbz_pend    <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rem      <= '0;
                        r_quo      <= w_dvd_mag;
                        r_dvs      <= w_dvs_mag;
                        r_dvd      <= dividend;
                        r_cnt      <= c_cnt_init;
                        r_qneg     <= w_dvd_neg ^ w_dvs_neg;
                        r_rneg     <= w_dvd_neg;
                        r_dbz_pend <= w_dvs_zero;
                    end
                end
                ST_ITER: begin
                    // Quotient bits enter at the LSB as dividend bits leave the MSB.
                    r_rem <= w_take ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_take};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_FIX: begin
                    if (r_dbz_pend) begin
                        r_quotient  <= c_dbz_quotient[WIDTH-1:0];
                        r_remainder <= r_dvd;
                    end else begin
                        r_quotient  <= r_qneg ? -r_quo : r_quo;
                        r_remainder <= r_rneg ? -r_rem : r_rem;
                    end
                    r_div_by_zero <= r_dbz_pend;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

`default_nettype wire

// File: tb/tb_divider_unit.sv
// ============================================================================
// Module   : tb_divider_unit
// Purpose  : Directed self-checking bench for divider_unit (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_pass;
    int n_total;

    divider_unit #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DIVIDER_ZERO_SHORTCUT_EN
    localparam int c_dbz_lat = 2;
`else
    localparam int c_dbz_lat = 34;
`endif

    // Issues one operation; lat = edges from accept to done visible, -1 on timeout.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, output int lat);
        int i;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        i = 1;
        while (lat < 0 && i <= 100) begin
            @(posedge clk);
            #1;
            if (done) lat = i;
            i++;
        end
    endtask

    task automatic test_reset();
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else n_pass++;
        n_total++; if (quotient !== 32'h0) $display("FAIL reset_quot got %h want 0", quotient); else n_pass++;
        n_total++; if (remainder !== 32'h0) $display("FAIL reset_rem got %h want 0", remainder); else n_pass++;
        n_total++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", div_by_zero); else n_pass++;
    endtask

    task automatic test_unsigned();
        int lat;
        run_div(32'd100, 32'd7, 1'b0, lat);
        n_total++; if (lat !== 34) $display("FAIL udiv_latency got %0d want 34", lat); else n_pass++;
        n_total++; if (quotient !== 32'd14) $display("FAIL udiv_quot got %h want %h", quotient, 32'd14); else n_pass++;
        n_total++; if (remainder !== 32'd2) $display("FAIL udiv_rem got %h want %h", remainder, 32'd2); else n_pass++;
        n_total++; if (div_by_zero !== 1'b0) $display("FAIL udiv_dbz got %b want 0", div_by_zero); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (done !== 1'b0) $display("FAIL done_pulse_width got %b want 0", done); else n_pass++;
    endtask

    task automatic test_signed();
        int lat;
        run_div(32'hFFFFFF9C, 32'd7, 1'b1, lat);
        n_total++; if (quotient !== 32'hFFFFFFF2) $display("FAIL sdiv_negdvd_quot got %h want fffffff2", quotient); else n_pass++;
        n_total++; if (remainder !== 32'hFFFFFFFE) $display("FAIL sdiv_negdvd_rem got %h want fffffffe", remainder); else n_pass++;
        run_div(32'd100, 32'hFFFFFFF9, 1'b1, lat);
        n_total++; if (lat !== 34) $display("FAIL sdiv_latency got %0d want 34", lat); else n_pass++;
        n_total++; if (quotient !== 32'hFFFFFFF2) $display("FAIL sdiv_negdvs_quot got %h want fffffff2", quotient); else n_pass++;
        n_total++; if (remainder !== 32'd2) $display("FAIL sdiv_negdvs_rem got %h want 2", remainder); else n_pass++;
    endtask

    task automatic test_div_by_zero();
        int lat;
        for (int s = 0; s < 2; s++) begin
            run_div(32'h12345678, 32'h0, s[0], lat);
            n_total++; if (lat !== c_dbz_lat) $display("FAIL dbz_latency signed=%0d got %0d want %0d", s, lat, c_dbz_lat); else n_pass++;
            n_total++; if (quotient !== 32'hFFFFFFFF) $display("FAIL dbz_quot signed=%0d got %h want ffffffff", s, quotient); else n_pass++;
            n_total++; if (remainder !== 32'h12345678) $display("FAIL dbz_rem signed=%0d got %h want 12345678", s, remainder); else n_pass++;
            n_total++; if (div_by_zero !== 1'b1) $display("FAIL dbz_flag signed=%0d got %b want 1", s, div_by_zero); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, lat);
        n_total++; if (quotient !== 32'h80000000) $display("FAIL ovf_signed_quot got %h want 80000000", quotient); else n_pass++;
        n_total++; if (remainder !== 32'h0) $display("FAIL ovf_signed_rem got %h want 0", remainder); else n_pass++;
        n_total++; if (div_by_zero !== 1'b0) $display("FAIL ovf_signed_dbz got %b want 0", div_by_zero); else n_pass++;
        run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, lat);
        n_total++; if (quotient !== 32'h0) $display("FAIL ovf_unsigned_quot got %h want 0", quotient); else n_pass++;
        n_total++; if (remainder !== 32'h80000000) $display("FAIL ovf_unsigned_rem got %h want 80000000", remainder); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int lat;
        int n_done;
        logic busy_at_req;
        @(negedge clk);
        dividend  = 32'd9;
        divisor   = 32'd2;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        n_done = 0;
        busy_at_req = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            if (i == 11) begin
                busy_at_req = busy;
                dividend = 32'd50;
                divisor  = 32'd5;
                start    = 1'b1;
            end
            if (i == 12) start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (lat < 0) lat = i;
            end
        end
        n_total++; if (busy_at_req !== 1'b1) $display("FAIL busy_midop got %b want 1", busy_at_req); else n_pass++;
        n_total++; if (lat !== 34) $display("FAIL busy_latency got %0d want 34", lat); else n_pass++;
        n_total++; if (n_done !== 1) $display("FAIL busy_done_count got %0d want 1", n_done); else n_pass++;
        n_total++; if (quotient !== 32'd4) $display("FAIL busy_quot got %h want 4", quotient); else n_pass++;
        n_total++; if (remainder !== 32'd1) $display("FAIL busy_rem got %h want 1", remainder); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL busy_idle got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        run_div(32'd9, 32'd2, 1'b0, lat);
        n_total++; if (quotient !== 32'd4) $display("FAIL b2b_first_quot got %h want 4", quotient); else n_pass++;
        @(posedge clk);
        run_div(32'd20, 32'd2, 1'b0, lat);
        n_total++; if (lat !== 34) $display("FAIL b2b_latency got %0d want 34", lat); else n_pass++;
        n_total++; if (quotient !== 32'd10) $display("FAIL b2b_quot got %h want a", quotient); else n_pass++;
        n_total++; if (remainder !== 32'd0) $display("FAIL b2b_rem got %h want 0", remainder); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        int lat;
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd3;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL rst_mid_done got %b want 0", done); else n_pass++;
        n_total++; if (quotient !== 32'h0) $display("FAIL rst_mid_quot got %h want 0", quotient); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        run_div(32'd1000, 32'd3, 1'b0, lat);
        n_total++; if (lat !== 34) $display("FAIL rst_after_latency got %0d want 34", lat); else n_pass++;
        n_total++; if (quotient !== 32'd333) $display("FAIL rst_after_quot got %h want %h", quotient, 32'd333); else n_pass++;
        n_total++; if (remainder !== 32'd1) $display("FAIL rst_after_rem got %h want 1", remainder); else n_pass++;
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = 32'h0;
        divisor   = 32'h0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
